// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// The master side drives write/read requests; the slave side is the FIFO.
interface sync_fifo_param_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] din;
   logic              rd_en;
   logic              flush;
   logic              clr_err;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, rd_en, flush, clr_err,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, flush, clr_err,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable thresholds, sticky error
// flags, synchronous flush and selectable first-word-fall-through read mode.
module sync_fifo_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2,
   parameter bit          FWFT      = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   sync_fifo_param_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [CW-1:0]     cnt;
   logic              empty_c;
   logic              full_c;
   logic              rd_ok;
   logic              wr_ok;
   logic              ovf_evt;
   logic              unf_evt;
   logic              ovf_q;
   logic              unf_q;

   assign empty_c = (cnt == '0);
   assign full_c  = (cnt == CW'(DEPTH));

   // Accept decisions; a flush cycle swallows both requests without errors.
   always_comb begin
      rd_ok   = 1'b0;
      wr_ok   = 1'b0;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (!bus.flush) begin
         rd_ok   = bus.rd_en && !empty_c;
         wr_ok   = bus.wr_en && (!full_c || bus.rd_en);
         ovf_evt = bus.wr_en && !wr_ok;
         unf_evt = bus.rd_en && !rd_ok;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= bus.din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Sticky error flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (ovf_evt) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_err) begin
            ovf_q <= 1'b0;
         end
         if (unf_evt) begin
            unf_q <= 1'b1;
         end else if (bus.clr_err) begin
            unf_q <= 1'b0;
         end
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word shown directly; gated to zero so an empty FIFO never exposes stale memory.
         assign bus.dout       = empty_c ? '0 : mem[rd_ptr];
         assign bus.dout_valid = !empty_c;
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;
         logic              dout_valid_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               dout_q       <= '0;
               dout_valid_q <= 1'b0;
            end else begin
               dout_valid_q <= rd_ok;
               if (rd_ok) begin
                  dout_q <= mem[rd_ptr];
               end
            end
         end

         assign bus.dout       = dout_q;
         assign bus.dout_valid = dout_valid_q;
      end
   endgenerate

   assign bus.count        = cnt;
   assign bus.empty        = empty_c;
   assign bus.full         = full_c;
   assign bus.almost_full  = (cnt >= CW'(AF_THRESH));
   assign bus.almost_empty = (cnt <= CW'(AE_THRESH));
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule
